// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - pipeline hazard controller: forwarding, load-use stall, branch flush, multi-cycle multiply
module hazard_unit_mc #(
  parameter int MUL_LAT    = 3,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  LoadE,
  input  logic                  PCSrcE,
  input  logic                  MulStartE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic                  mul_busy,
  output logic                  mul_done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic       MULTI    = (MUL_LAT > 1);
  localparam logic [3:0] CNT_INIT = MULTI ? 4'(MUL_LAT - 2) : 4'd0;

  logic [0:0] state;
  logic [3:0] cnt;
  logic       lw_stall;
  logic       mul_stall;
  logic       mul_start;
  logic       done;

  // Memory stage has the younger result, so it wins over Writeback; x0 is never forwarded.
  function automatic logic [1:0] fwd(input logic [REG_ADDR_W-1:0] rs);
    if (RegWriteM && (RdM == rs) && (RdM != '0))
      return 2'b10;
    else if (RegWriteW && (RdW == rs) && (RdW != '0))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    lw_stall  = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    mul_start = (state == IDLE) && MulStartE && !PCSrcE && MULTI;
    mul_stall = mul_start || ((state == BUSY) && (cnt != 4'd0));
    done      = (state == IDLE) ? (!MULTI && MulStartE) : (cnt == 4'd0);

    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    mul_busy  = 1'b0;
    mul_done  = 1'b0;
    if (!reset) begin
      ForwardAE = fwd(Rs1E);
      ForwardBE = fwd(Rs2E);
      StallF    = lw_stall || mul_stall;
      StallD    = lw_stall || mul_stall;
      StallE    = mul_stall;
      FlushD    = PCSrcE;
      // A held multiply keeps Execute occupied, so no bubble may overwrite it.
      FlushE    = (lw_stall || PCSrcE) && !mul_stall;
      FlushM    = mul_stall;
      mul_busy  = (state == BUSY);
      mul_done  = done;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mul_start) begin
            state <= BUSY;
            cnt   <= CNT_INIT;
          end
        end
        default: begin
          // The release cycle still sees MulStartE for the same instruction; it must not restart.
          if (cnt != 4'd0)
            cnt <= cnt - 4'd1;
          else
            state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - scoreboard bench for hazard_unit_mc at MUL_LAT 3 and 1
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, LoadE, PCSrcE, MulStartE;
  wire  [11:0] o3;
  wire  [11:0] o1;

  always #5 clk = ~clk;

  hazard_unit_mc #(.MUL_LAT(3), .REG_ADDR_W(5)) dut3 (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MulStartE(MulStartE),
    .ForwardAE(o3[11:10]), .ForwardBE(o3[9:8]), .StallF(o3[7]), .StallD(o3[6]),
    .StallE(o3[5]), .FlushD(o3[4]), .FlushE(o3[3]), .FlushM(o3[2]),
    .mul_busy(o3[1]), .mul_done(o3[0])
  );

  hazard_unit_mc #(.MUL_LAT(1), .REG_ADDR_W(5)) dut1 (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MulStartE(MulStartE),
    .ForwardAE(o1[11:10]), .ForwardBE(o1[9:8]), .StallF(o1[7]), .StallD(o1[6]),
    .StallE(o1[5]), .FlushD(o1[4]), .FlushE(o1[3]), .FlushM(o1[2]),
    .mul_busy(o1[1]), .mul_done(o1[0])
  );

  typedef struct {
    logic [11:0] exp3;
    logic [11:0] exp1;
    string       tag;
  } item_t;

  item_t sbq[$];
  int    errors = 0;
  int    checks = 0;
  int    rem3   = 0;   // cycles the multiply still owns Execute, current one included
  int    rem1   = 0;
  bit    drive_done = 1'b0;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM == rs && RdM != 0) return 2'b10;
    if (RegWriteW && RdW == rs && RdW != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [11:0] ref_out(input int lat, input int rem, output int rem_n);
    logic lw, ms, done, busy;
    lw = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    if (rem == 0) begin
      busy  = 1'b0;
      ms    = MulStartE && !PCSrcE && lat > 1;
      done  = (lat == 1) && MulStartE;
      rem_n = ms ? lat - 1 : 0;
    end else begin
      busy  = 1'b1;
      ms    = rem > 1;
      done  = rem == 1;
      rem_n = rem - 1;
    end
    if (reset) begin
      rem_n = 0;
      return 12'h000;
    end
    return {ref_fwd(Rs1E), ref_fwd(Rs2E), lw | ms, lw | ms, ms, PCSrcE,
            (lw | PCSrcE) & ~ms, ms, busy, done};
  endfunction

  task automatic clr();
    reset = 1'b0; Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; LoadE = 0; PCSrcE = 0; MulStartE = 0;
  endtask

  // Inputs are already applied; record expectation, advance the model, move to the next cycle.
  task automatic step(input string tag);
    item_t it;
    int    n3, n1;
    it.exp3 = ref_out(3, rem3, n3);
    it.exp1 = ref_out(1, rem1, n1);
    it.tag  = tag;
    sbq.push_back(it);
    rem3 = n3;
    rem1 = n1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      item_t it;
      it = sbq.pop_front();
      checks += 2;
      if (o3 !== it.exp3) begin
        errors++;
        $display("FAIL %s lat3 got=%b exp=%b", it.tag, o3, it.exp3);
      end
      if (o1 !== it.exp1) begin
        errors++;
        $display("FAIL %s lat1 got=%b exp=%b", it.tag, o1, it.exp1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout drive_done=%0d pending=%0d", drive_done, sbq.size());
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    reset = 1'b1;
    @(posedge clk); #1;
    step("reset0");
    step("reset1");
    clr();

    RegWriteM = 1; RdM = 5; Rs1E = 5; RegWriteW = 1; RdW = 5; step("fwd_m_wins");
    RegWriteM = 0; step("fwd_w");
    clr(); RegWriteM = 1; RdM = 0; Rs2E = 0; RegWriteW = 1; RdW = 0; step("fwd_x0");
    clr(); LoadE = 1; RdE = 7; Rs2D = 7; step("lw_stall");
    PCSrcE = 1; step("branch_lw");
    clr(); PCSrcE = 1; MulStartE = 1; step("branch_mul");
    clr(); step("after_branch_mul");
    MulStartE = 1; step("mul_c1");
    step("mul_c2");
    step("mul_c3");
    clr(); step("mul_after");
    MulStartE = 1; step("mul_rst_a");
    reset = 1; step("mul_rst_b");
    clr(); step("mul_rst_c");
    step("mul_rst_d");
    LoadE = 1; RdE = 3; Rs1D = 3; MulStartE = 1; step("lw_and_mul");
    step("lw_and_mul2");
    clr(); step("idle");

    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 49) == 0);
      Rs1D      = 5'($urandom_range(0, 3));
      Rs2D      = 5'($urandom_range(0, 3));
      Rs1E      = 5'($urandom_range(0, 3));
      Rs2E      = 5'($urandom_range(0, 3));
      RdE       = 5'($urandom_range(0, 3));
      RdM       = 5'($urandom_range(0, 3));
      RdW       = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      LoadE     = ($urandom_range(0, 3) == 0);
      PCSrcE    = ($urandom_range(0, 5) == 0);
      MulStartE = ($urandom_range(0, 2) == 0);
      step("rand");
    end
    clr();
    drive_done = 1'b1;
    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
    if (sbq.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
